dma_mem_responder: RTL and testbench

Host-side responder for the simplified DMA read/write interface. It is the counterpart of the `dma_if.peripheral` port that an AFU drives, and it backs both channels with an on-chip cacheline RAM. It lets AFUs such as the miner/memory-controller path be simulated and hardware-tested without CCI-P or a host. A backdoor port preloads and inspects the RAM.

---
 rtl/dma_mem_responder.sv | 212 +++++++++++++++++++++
 tb/tb_dma_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_responder.sv
// Host-side DMA responder: serves dma_if read/write channels from an on-chip
// cacheline RAM, with a backdoor port for preload and inspection.
module dma_mem_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43,
  parameter int DATA_WIDTH = 512,
  parameter int MEM_LINES  = 1024,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W     = $clog2(MEM_LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SIZE_WIDTH-1:0] rd_size,
  input  logic                  rd_go,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_done,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] wr_size,
  input  logic                  wr_go,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  wr_done,
  input  logic                  bd_we,
  input  logic [IDX_W-1:0]      bd_addr,
  input  logic [DATA_WIDTH-1:0] bd_wdata,
  output logic [DATA_WIDTH-1:0] bd_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RD_IDLE, RD_FETCH}  rd_state_e;
  typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_e;

  logic [DATA_WIDTH-1:0] mem_q [MEM_LINES];
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

  rd_state_e             rd_state_q, rd_state_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [SIZE_WIDTH-1:0] rd_rem_q, rd_rem_d;
  logic [SIZE_WIDTH-1:0] pop_rem_q, pop_rem_d;
  logic                  rd_done_q, rd_done_d;

  wr_state_e             wr_state_q, wr_state_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [SIZE_WIDTH-1:0] wr_rem_q, wr_rem_d;
  logic                  wr_done_q, wr_done_d;

  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;

  logic                  vld_p0_q, vld_p1_q;
  logic [DATA_WIDTH-1:0] ram_rdata_p0_q;
  logic [DATA_WIDTH-1:0] data_p1_q;

  logic [CNT_W-1:0]      in_flight;
  logic                  rd_issue;
  logic                  rd_pop;
  logic                  fifo_push;
  logic                  wr_accept;
  logic                  bd_accept;
  logic [IDX_W-1:0]      raddr;

  // Offset and out-of-range address bits carry no meaning for line indexing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[5:0], rd_addr[ADDR_WIDTH-1:6+IDX_W],
                              wr_addr[5:0], wr_addr[ADDR_WIDTH-1:6+IDX_W]};

  assign empty     = (fifo_cnt_q == '0);
  assign rd_data   = empty ? '0 : fifo_mem_q[rptr_q];
  assign rd_done   = rd_done_q;
  assign in_flight = CNT_W'(vld_p0_q) + CNT_W'(vld_p1_q);
  assign rd_issue  = (rd_state_q == RD_FETCH) && (rd_rem_q != '0) && !rd_go &&
                     ((fifo_cnt_q + in_flight) < CNT_W'(FIFO_DEPTH));
  assign rd_pop    = rd_en && !empty && !rd_go;
  assign fifo_push = vld_p1_q && !rd_go;
  assign raddr     = rd_issue ? rd_idx_q : bd_addr;

  assign full      = !((wr_state_q == WR_ACTIVE) && (wr_rem_q != '0));
  assign wr_done   = wr_done_q;
  assign wr_accept = !full && wr_en && !wr_go && !rst;
  assign bd_accept = bd_we && (wr_state_q == WR_IDLE) && !rst;
  assign bd_rdata  = ram_rdata_p0_q;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_rem_d   = rd_rem_q;
    pop_rem_d  = pop_rem_q;
    rd_done_d  = rd_done_q;
    if (rd_go) begin
      rd_idx_d   = rd_addr[6 +: IDX_W];
      rd_rem_d   = rd_size;
      pop_rem_d  = rd_size;
      rd_done_d  = (rd_size == '0);
      rd_state_d = (rd_size == '0) ? RD_IDLE : RD_FETCH;
    end else begin
      if (rd_issue) begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
        rd_rem_d = rd_rem_q - SIZE_WIDTH'(1);
        if (rd_rem_q == SIZE_WIDTH'(1)) rd_state_d = RD_IDLE;
      end
      if (rd_pop) begin
        pop_rem_d = pop_rem_q - SIZE_WIDTH'(1);
        if (pop_rem_q == SIZE_WIDTH'(1)) rd_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (rd_go) begin
      fifo_cnt_d = '0;
      wptr_d     = '0;
      rptr_d     = '0;
    end else begin
      if (fifo_push) wptr_d = wptr_q + PTR_W'(1);
      if (rd_pop)    rptr_d = rptr_q + PTR_W'(1);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(rd_pop);
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_rem_d   = wr_rem_q;
    wr_done_d  = wr_done_q;
    if (wr_go) begin
      wr_idx_d   = wr_addr[6 +: IDX_W];
      wr_rem_d   = wr_size;
      wr_done_d  = (wr_size == '0);
      wr_state_d = (wr_size == '0) ? WR_IDLE : WR_ACTIVE;
    end else if (wr_accept) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
      wr_rem_d = wr_rem_q - SIZE_WIDTH'(1);
      if (wr_rem_q == SIZE_WIDTH'(1)) begin
        wr_state_d = WR_IDLE;
        wr_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rd_idx_q   <= '0;
      rd_rem_q   <= '0;
      pop_rem_q  <= '0;
      rd_done_q  <= 1'b0;
      wr_state_q <= WR_IDLE;
      wr_idx_q   <= '0;
      wr_rem_q   <= '0;
      wr_done_q  <= 1'b0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_rem_q   <= rd_rem_d;
      pop_rem_q  <= pop_rem_d;
      rd_done_q  <= rd_done_d;
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_rem_q   <= wr_rem_d;
      wr_done_q  <= wr_done_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Stage p0: RAM read register, shared by fetch and the backdoor port.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q       <= 1'b0;
      ram_rdata_p0_q <= '0;
    end else begin
      vld_p0_q       <= rd_issue;
      ram_rdata_p0_q <= mem_q[raddr];
    end
  end

  // Stage p1: retiming register ahead of the FIFO; a restart squashes it.
  always_ff @(posedge clk) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p0_q && !rd_go;
  end

  always_ff @(posedge clk) begin
    data_p1_q <= ram_rdata_p0_q;
  end

  // Stage p2: FIFO storage write.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[wptr_q] <= data_p1_q;
  end

  // Read-first RAM: the read above samples old contents on a same-line write.
  always_ff @(posedge clk) begin
    if (wr_accept)      mem_q[wr_idx_q] <= wr_data;
    else if (bd_accept) mem_q[bd_addr]  <= bd_wdata;
  end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Scoreboarded bench for dma_mem_responder: directed read/write/backdoor
// scenarios with a negedge monitor comparing every popped line.
module tb_dma_mem_responder;

  localparam int AW = 64;
  localparam int SW = 43;
  localparam int DW = 512;
  localparam int ML = 1024;
  localparam int FD = 4;
  localparam int IW = 10;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_size;
  logic          rd_go;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          rd_done;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_size;
  logic          wr_go;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          wr_done;
  logic          bd_we;
  logic [IW-1:0] bd_addr;
  logic [DW-1:0] bd_wdata;
  logic [DW-1:0] bd_rdata;

  dma_mem_responder #(
    .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW),
    .MEM_LINES(ML), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_size(rd_size), .rd_go(rd_go), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
    .wr_addr(wr_addr), .wr_size(wr_size), .wr_go(wr_go), .wr_en(wr_en),
    .wr_data(wr_data), .full(full), .wr_done(wr_done),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  int            max_occ = 0;
  bit            occ_en = 1'b0;

  function automatic logic [DW-1:0] pat(input int i);
    return {16{32'hC0DE0000 + 32'(i)}};
  endfunction

  function automatic logic [DW-1:0] wpat(input int i);
    return {16{32'hBEEF0000 + 32'(i)}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input int a, input logic [DW-1:0] d);
    bd_we    = 1'b1;
    bd_addr  = IW'(a);
    bd_wdata = d;
    tick();
    bd_we    = 1'b0;
  endtask

  task automatic bd_check(input string nm, input int a, input logic [DW-1:0] e);
    bd_addr = IW'(a);
    tick();
    chk(nm, bd_rdata, e);
  endtask

  task automatic wait_rd_done(input string nm, input int maxc);
    int n;
    n = 0;
    while (!rd_done && n < maxc) begin
      tick();
      n++;
    end
    chkb({nm, "_done"}, rd_done, 1'b1);
    chki({nm, "_drained"}, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: a pop happens at the next edge when rd_en & !empty & !rd_go.
  always @(negedge clk) begin
    if (!rst && rd_en && !empty && !rd_go) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h expected no data", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
    if (occ_en) begin
      if (int'(dut.fifo_cnt_q) + int'(dut.vld_p0_q) + int'(dut.vld_p1_q) > max_occ)
        max_occ = int'(dut.fifo_cnt_q) + int'(dut.vld_p0_q) + int'(dut.vld_p1_q);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nw;
    int n;
    rst = 1'b1; rd_addr = '0; rd_size = '0; rd_go = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_size = '0; wr_go = 1'b0; wr_en = 1'b0; wr_data = '0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    tick();
    tick();
    chkb("rst_empty", empty, 1'b1);
    chkb("rst_full", full, 1'b1);
    chkb("rst_rd_done", rd_done, 1'b0);
    chkb("rst_wr_done", wr_done, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_bd_rdata", bd_rdata, '0);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) bd_write(i, pat(i));
    for (int i = 256; i < 264; i++) bd_write(i, pat(i));
    for (int i = 512; i < 518; i++) bd_write(i, pat(i));
    bd_write(1022, pat(1022));
    bd_write(1023, pat(1023));

    // Writes before any wr_go are dropped.
    wr_data = wpat(99);
    wr_en = 1'b1;
    repeat (3) tick();
    wr_en = 1'b0;
    bd_check("wr_before_go", 0, pat(0));

    // Zero-size transfers.
    rd_size = '0; rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    chkb("size0_rd_done", rd_done, 1'b1);
    chkb("size0_empty", empty, 1'b1);
    rd_en = 1'b1;
    repeat (3) tick();
    chkb("size0_empty_held", empty, 1'b1);
    rd_en = 1'b0;
    wr_size = '0; wr_go = 1'b1;
    tick();
    wr_go = 1'b0;
    chkb("size0_wr_done", wr_done, 1'b1);
    chkb("size0_full", full, 1'b1);

    // Streaming read of 16 lines, latency and done timing.
    for (int i = 0; i < 16; i++) exp_q.push_back(pat(i));
    rd_addr = '0; rd_size = SW'(16); rd_go = 1'b1;
    tick();
    rd_go = 1'b0; rd_en = 1'b1;
    chkb("lat_e0_empty", empty, 1'b1);
    tick();
    chkb("lat_e1_empty", empty, 1'b1);
    tick();
    chkb("lat_e2_empty", empty, 1'b1);
    tick();
    chkb("lat_e3_nonempty", empty, 1'b0);
    repeat (15) tick();
    chkb("rd16_done_early", rd_done, 1'b0);
    tick();
    chkb("rd16_done", rd_done, 1'b1);
    chkb("rd16_empty_after", empty, 1'b1);
    rd_en = 1'b0;
    chki("rd16_drained", exp_q.size(), 0);

    // Loopback lines 0..7 into line 256..263.
    for (int i = 0; i < 8; i++) exp_q.push_back(pat(i));
    rd_addr = '0; rd_size = SW'(8); wr_addr = 64'h4000; wr_size = SW'(8);
    rd_go = 1'b1; wr_go = 1'b1;
    tick();
    rd_go = 1'b0; wr_go = 1'b0;
    chkb("loop_full_drop", full, 1'b0);
    nw = 0;
    n = 0;
    while (nw < 8 && n < 100) begin
      rd_en = !empty;
      wr_en = !empty;
      wr_data = rd_data;
      tick();
      n++;
      if (wr_en) begin
        nw++;
        if (nw == 7) chkb("loop_wr_done_early", wr_done, 1'b0);
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    chkb("loop_wr_done", wr_done, 1'b1);
    chkb("loop_full_after", full, 1'b1);
    for (int i = 0; i < 8; i++) bd_check("loop_ram", 256 + i, pat(i));

    // Index wrap with junk in offset and upper address bits.
    exp_q.push_back(pat(1022));
    exp_q.push_back(pat(1023));
    exp_q.push_back(pat(0));
    exp_q.push_back(pat(1));
    rd_addr = 64'hABCD_0000_0000_0000 | 64'(1022 * 64) | 64'h15;
    rd_size = SW'(4); rd_go = 1'b1;
    tick();
    rd_go = 1'b0; rd_en = 1'b1;
    wait_rd_done("wrap", 50);
    rd_en = 1'b0;

    // Backpressure: pop every third cycle.
    for (int i = 16; i < 26; i++) exp_q.push_back(pat(i));
    rd_addr = 64'(16 * 64); rd_size = SW'(10);
    max_occ = 0;
    occ_en = 1'b1;
    rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    n = 0;
    while (!rd_done && n < 300) begin
      rd_en = (n % 3 == 0);
      tick();
      n++;
    end
    rd_en = 1'b0;
    occ_en = 1'b0;
    chkb("bp_done", rd_done, 1'b1);
    chki("bp_drained", exp_q.size(), 0);
    chkb("bp_occupancy_bound", max_occ <= FD, 1'b1);

    // Restart after three pops; the go cycle also carries rd_en.
    exp_q.push_back(pat(0));
    exp_q.push_back(pat(1));
    exp_q.push_back(pat(2));
    rd_addr = '0; rd_size = SW'(8); rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    n = 0;
    while (empty && n < 20) begin
      tick();
      n++;
    end
    chkb("restart_first", empty, 1'b0);
    rd_en = 1'b1;
    repeat (3) tick();
    for (int i = 32; i < 40; i++) exp_q.push_back(pat(i));
    rd_addr = 64'h800; rd_size = SW'(8); rd_go = 1'b1;
    tick();
    rd_go = 1'b0;
    chkb("restart_flush", empty, 1'b1);
    chkb("restart_done_clr", rd_done, 1'b0);
    wait_rd_done("restart", 60);
    rd_en = 1'b0;

    // Reset in the middle of a write burst.
    wr_addr = 64'(512 * 64); wr_size = SW'(8); wr_go = 1'b1;
    tick();
    wr_go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1;
      wr_data = wpat(k);
      tick();
    end
    rst = 1'b1;
    wr_data = wpat(3);
    tick();
    chkb("rst_mid_full", full, 1'b1);
    wr_data = wpat(4);
    tick();
    rst = 1'b0;
    wr_data = wpat(5);
    tick();
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) bd_check("rst_mid_written", 512 + i, wpat(i));
    for (int i = 3; i < 6; i++) bd_check("rst_mid_untouched", 512 + i, pat(512 + i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
